// File: rtl/low_to_high.sv
// rtl/low_to_high.sv - gathers 2^BRUST_SIZE_LOG narrow beats into one wide word
//
// Purpose: receive-side width bridge. Narrow beats arrive one per
// valid/finish handshake and are packed LSB-first into a wide word.
// The finished word is then offered on the wide side until the consumer
// acknowledges it.
//
// Ports:
//   clk                clock, rising edge
//   rst                synchronous active-high reset
//   low_read_valid     narrow beat present (held until low_read_finish)
//   low_read_data      narrow beat, LOW_DATA_WIDTH bits
//   low_read_finish    one-cycle acknowledge of an accepted beat
//   high_write_valid   assembled wide word available (level)
//   high_write_finish  consumer took the wide word (one-cycle pulse)
//   high_write_data    assembled word, beat k at [k*W +: W]

module low_to_high #(
    parameter int LOW_DATA_WIDTH = 32,
    parameter int BRUST_SIZE_LOG = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          low_read_valid,
    input  logic [LOW_DATA_WIDTH-1:0]                     low_read_data,
    output logic                                          low_read_finish,
    output logic                                          high_write_valid,
    input  logic                                          high_write_finish,
    output logic [LOW_DATA_WIDTH*(2**BRUST_SIZE_LOG)-1:0] high_write_data
);

    localparam int N = 2 ** BRUST_SIZE_LOG;
    localparam logic [BRUST_SIZE_LOG-1:0] LAST_BEAT = '1;

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_t;

    state_t                    state;
    logic [BRUST_SIZE_LOG-1:0] beat_counter;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= COLLECT;
            beat_counter     <= '0;
            low_read_finish  <= 1'b0;
            high_write_valid <= 1'b0;
            high_write_data  <= '0;
        end else begin
            // Finish is a single-cycle pulse; only an accept re-raises it.
            low_read_finish <= 1'b0;
            case (state)
                COLLECT: begin
                    // The producer holds valid until it sees finish, so the
                    // cycle in which finish is high must not accept again.
                    if (low_read_valid && !low_read_finish) begin
                        high_write_data[int'(beat_counter)*LOW_DATA_WIDTH +: LOW_DATA_WIDTH]
                            <= low_read_data;
                        low_read_finish <= 1'b1;
                        beat_counter    <= beat_counter + 1'b1;
                        if (beat_counter == LAST_BEAT) begin
                            state            <= OUTPUT;
                            high_write_valid <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    // Narrow side is stalled here; the word stays frozen.
                    if (high_write_finish) begin
                        high_write_valid <= 1'b0;
                        state            <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_low_to_high.sv
// tb/tb_low_to_high.sv - directed self-checking bench for low_to_high

module tb_low_to_high;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance: W=32, LOG=2
    logic         lv, lrf, hwv, hwf;
    logic [31:0]  ld;
    logic [127:0] hwd;

    // Sweep instance: W=8, LOG=1
    logic         v1, f1, hv1, hf1;
    logic [7:0]   d1;
    logic [15:0]  hd1;

    // Sweep instance: W=8, LOG=3
    logic         v3, f3, hv3, hf3;
    logic [7:0]   d3;
    logic [63:0]  hd3;

    int n_checks = 0;
    int n_fail   = 0;

    low_to_high #(.LOW_DATA_WIDTH(32), .BRUST_SIZE_LOG(2)) dut (
        .clk(clk), .rst(rst),
        .low_read_valid(lv), .low_read_data(ld), .low_read_finish(lrf),
        .high_write_valid(hwv), .high_write_finish(hwf), .high_write_data(hwd)
    );

    low_to_high #(.LOW_DATA_WIDTH(8), .BRUST_SIZE_LOG(1)) dut_s1 (
        .clk(clk), .rst(rst),
        .low_read_valid(v1), .low_read_data(d1), .low_read_finish(f1),
        .high_write_valid(hv1), .high_write_finish(hf1), .high_write_data(hd1)
    );

    low_to_high #(.LOW_DATA_WIDTH(8), .BRUST_SIZE_LOG(3)) dut_s3 (
        .clk(clk), .rst(rst),
        .low_read_valid(v3), .low_read_data(d3), .low_read_finish(f3),
        .high_write_valid(hv3), .high_write_finish(hf3), .high_write_data(hd3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Splitter-style producer: one-cycle valid pulse, 3-cycle spacing.
    task automatic pulse(input logic [31:0] d, input logic last);
        lv = 1'b1;
        ld = d;
        tick();
        check("beat_finish", lrf, 1);
        check("beat_hwv", hwv, last);
        lv = 1'b0;
        tick();
        check("finish_drop", lrf, 0);
        tick();
    endtask

    task automatic consume();
        hwf = 1'b1;
        tick();
        hwf = 1'b0;
        check("consume_hwv", hwv, 0);
        check("consume_no_finish", lrf, 0);
    endtask

    logic [31:0]  lvl_beats [4];
    logic [127:0] word;
    logic [15:0]  exp1;
    logic [63:0]  exp3;
    logic [7:0]   b;

    initial begin
        rst = 1'b1;
        lv = 1'b0; ld = '0; hwf = 1'b0;
        v1 = 1'b0; d1 = '0; hf1 = 1'b0;
        v3 = 1'b0; d3 = '0; hf3 = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_finish", lrf, 0);
        check("rst_hwv", hwv, 0);
        check("rst_data", hwd, 0);
        check("rst_s1", {hv1, f1, hd1}, 0);
        check("rst_s3", {hv3, f3, hd3}, 0);

        // Single word with pulsed beats
        pulse(32'h11111111, 1'b0);
        pulse(32'h22222222, 1'b0);
        pulse(32'h33333333, 1'b0);
        lv = 1'b1;
        ld = 32'h44444444;
        tick();
        check("w1_last_finish", lrf, 1);
        check("w1_hwv_rise", hwv, 1);
        check("w1_data", hwd, 128'h44444444_33333333_22222222_11111111);
        lv = 1'b0;
        tick();
        tick();
        check("w1_hwv_hold", hwv, 1);
        consume();

        // Level-held valid: accepts at t, t+2, t+4, t+6
        lvl_beats[0] = 32'hA1A1A1A1;
        lvl_beats[1] = 32'hB2B2B2B2;
        lvl_beats[2] = 32'hC3C3C3C3;
        lvl_beats[3] = 32'hD4D4D4D4;
        lv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ld = lvl_beats[k];
            tick();
            check("lvl_accept", lrf, 1);
            check("lvl_hwv", hwv, (k == 3));
            tick();
            check("lvl_no_dup", lrf, 0);
        end
        lv = 1'b0;
        check("lvl_data", hwd, 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1);
        consume();

        // Backpressure: next beat held while the word is pending
        pulse(32'h01010101, 1'b0);
        pulse(32'h02020202, 1'b0);
        pulse(32'h03030303, 1'b0);
        pulse(32'h04040404, 1'b1);
        word = 128'h04040404_03030303_02020202_01010101;
        lv = 1'b1;
        ld = 32'hAAAAAAAA;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stall_no_finish", lrf, 0);
            check("stall_hwv", hwv, 1);
            check("stall_data", hwd, word);
        end
        hwf = 1'b1;
        tick();
        hwf = 1'b0;
        check("bp_hwv_drop", hwv, 0);
        check("bp_no_same_cycle_accept", lrf, 0);
        tick();
        check("bp_accept", lrf, 1);
        check("bp_slice0", hwd, {word[127:32], 32'hAAAAAAAA});
        lv = 1'b0;
        tick();
        tick();
        pulse(32'hBBBBBBBB, 1'b0);
        pulse(32'hCCCCCCCC, 1'b0);
        pulse(32'hDDDDDDDD, 1'b1);
        check("bp_word", hwd, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        consume();

        // high_write_finish in COLLECT is ignored
        pulse(32'h10101010, 1'b0);
        pulse(32'h20202020, 1'b0);
        hwf = 1'b1;
        tick();
        hwf = 1'b0;
        check("collect_hwf_hwv", hwv, 0);
        check("collect_hwf_finish", lrf, 0);
        pulse(32'h30303030, 1'b0);
        pulse(32'h40404040, 1'b1);
        check("collect_hwf_word", hwd, 128'h40404040_30303030_20202020_10101010);
        consume();

        // Reset mid-word
        pulse(32'h00000001, 1'b0);
        pulse(32'h00000002, 1'b0);
        lv = 1'b1;
        ld = 32'h00000003;
        tick();
        check("mid_accept3", lrf, 1);
        lv = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_finish", lrf, 0);
        check("mid_rst_hwv", hwv, 0);
        check("mid_rst_data", hwd, 0);
        tick();
        pulse(32'h00000005, 1'b0);
        pulse(32'h00000006, 1'b0);
        pulse(32'h00000007, 1'b0);
        pulse(32'h00000008, 1'b1);
        check("mid_rst_word", hwd, 128'h00000008_00000007_00000006_00000005);
        consume();

        // Sweep LOG=1, W=8: three back-to-back words
        for (int w = 0; w < 3; w++) begin
            exp1 = '0;
            for (int k = 0; k < 2; k++) begin
                b = 8'(w * 16 + k + 1);
                exp1[k*8 +: 8] = b;
                v1 = 1'b1;
                d1 = b;
                tick();
                check("s1_finish", f1, 1);
                check("s1_hwv", hv1, (k == 1));
                v1 = 1'b0;
                tick();
            end
            check("s1_word", hd1, exp1);
            hf1 = 1'b1;
            tick();
            hf1 = 1'b0;
            check("s1_hwv_drop", hv1, 0);
        end

        // Sweep LOG=3, W=8: two back-to-back words
        for (int w = 0; w < 2; w++) begin
            exp3 = '0;
            for (int k = 0; k < 8; k++) begin
                b = 8'(8'hA0 + w * 16 + k);
                exp3[k*8 +: 8] = b;
                v3 = 1'b1;
                d3 = b;
                tick();
                check("s3_finish", f3, 1);
                check("s3_hwv", hv3, (k == 7));
                v3 = 1'b0;
                tick();
            end
            check("s3_word", hd3, exp3);
            hf3 = 1'b1;
            tick();
            hf3 = 1'b0;
            check("s3_hwv_drop", hv3, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/low_to_high.md
# low_to_high

Width-gathering bus bridge: accepts 2^BRUST_SIZE_LOG consecutive narrow beats from a low-width bus and presents them as one wide word on a high-width bus. It is the receive-side counterpart of the wide-to-narrow splitter in the bus_decode path. It sits between a narrow producer, which drives valid and waits for finish per beat, and a wide consumer, which takes one word per valid/finish handshake. Beat 0 lands in the least-significant slice.

## Interface
- LOW_DATA_WIDTH, 32, width of one narrow beat in bits
- BRUST_SIZE_LOG, 2, log2 of beats per wide word; legal range >= 1; N = 2^BRUST_SIZE_LOG
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- low_read_valid  input  1  narrow beat present on low_read_data; producer holds it until low_read_finish is seen
- low_read_data  input  LOW_DATA_WIDTH  narrow beat
- low_read_finish  output  1  one-cycle pulse acknowledging one accepted beat
- high_write_valid  output  1  assembled wide word available; level, held until finish
- high_write_finish  input  1  consumer has taken the wide word; single-cycle pulse
- high_write_data  output  LOW_DATA_WIDTH*N  assembled word; beat k occupies bits [k*LOW_DATA_WIDTH +: LOW_DATA_WIDTH]

## Operation
- FSM with 2 states: COLLECT (reset state) and OUTPUT.
- beat_counter: BRUST_SIZE_LOG bits, reset 0. It counts accepted beats in the current word.
- Accept condition, evaluated every cycle: state==COLLECT && low_read_valid && !low_read_finish.
  - The !low_read_finish term stops a level-held valid from being accepted twice.
- On accept:
  - high_write_data[beat_counter*W +: W] <= low_read_data; other slices are unchanged.
  - low_read_finish <= 1 for exactly the next cycle.
  - beat_counter <= beat_counter+1, wrapping modulo N.
- Accept with beat_counter==N-1 (last beat):
  - next state OUTPUT.
  - high_write_valid <= 1.
  - beat_counter wraps to 0.
- OUTPUT:
  - high_write_data is frozen.
  - low_read_valid is ignored; no finish is generated, and the producer keeps valid asserted and waits.
- OUTPUT && high_write_finish:
  - high_write_valid <= 0; next state COLLECT.
  - No beat is accepted in that same cycle. The first beat of the next word can be accepted the following cycle at the earliest.
- high_write_finish in COLLECT is ignored, with no state or output effect.
- Reset values:
  - state COLLECT, beat_counter 0.
  - low_read_finish 0, high_write_valid 0, high_write_data 0.
- Reset mid-word discards the partially collected beats. Reset in OUTPUT drops the pending word with no finish.
- high_write_data outside OUTPUT shows partial contents and is meaningful only while high_write_valid=1.

## Timing
- Beat sampled at edge t (valid=1, accept condition true): data slice and counter update at t; low_read_finish is high during cycle t..t+1.
- Level-held valid: the earliest next accept is at edge t+2, after the producer drops valid or presents the next beat. Peak rate is 1 beat per 2 cycles.
- Pulsed valid, as the splitter-style producer drives it (valid 1 cycle, wait for finish, re-pulse): every pulse that arrives in COLLECT with finish low is accepted.
- Last beat accepted at edge t: high_write_valid rises at t, in the same cycle as that beat's low_read_finish. Latency from last-beat valid to wide valid is 1 cycle.
- high_write_finish sampled at edge u: high_write_valid low from u.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Single word, W=32, LOG=2: beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 as 1-cycle pulses spaced 3 cycles.
  - Expect 4 finish pulses, each 1 cycle after its beat.
  - high_write_valid rises with the 4th finish; high_write_data = 0x44444444_33333333_22222222_11111111.
  - valid holds until high_write_finish, then drops the next cycle.
- Level-held valid: producer holds valid until finish, then re-asserts with the next beat immediately.
  - Exactly one accept per beat, with no duplicated slices.
  - Beats accepted at edges t, t+2, t+4, t+6.
- Backpressure: send 4 beats, then present beat 0xAAAAAAAA held while high_write_valid=1 and high_write_finish is withheld for 10 cycles.
  - No finish and no data change during the stall.
  - After finish, 0xAAAAAAAA is accepted at least 1 cycle later into slice 0.
- Boundary: high_write_finish pulsed in COLLECT after 2 beats → ignored; the counter stays at 2 and the word completes normally after 2 more beats.
- Reset mid-word: accept 3 beats, assert rst for 1 cycle.
  - All outputs go to 0 and the counter goes to 0.
  - The next 4 beats (0x5..0x8) yield 0x00000008_00000007_00000006_00000005.
- Parameter sweep: LOG=1 and LOG=3 with W=8, back-to-back words.
  - Correct slice order every word; the counter wraps correctly.
